// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch-stage PC register and next-PC selection.
// Holds the fetch PC and applies ID-stage redirects (branch, J, JR),
// exception entry and ERET. A redirect that arrives while fetch is stalled
// is kept in a one-entry pending slot until fetch can take it.
// Optional return-address stack, enabled by defining PC_GEN_RAS_EN.
// In the default build the stack is absent, is_call/is_ret are ignored and
// ras_miss is tied low.
module pc_gen_unit #(
    parameter int          ADDR_W    = 32,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC   = 32'h0000_4180,
    parameter int          RAS_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        npc_sel,
    input  logic              judge,
    input  logic [ADDR_W-1:0] id_pc4,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_out,
    input  logic              is_call,
    input  logic              is_ret,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc4,
    output logic              if_jump,
    output logic              pend_valid,
    output logic              ras_miss
);

    // state   | meaning
    // RUN     | no redirect waiting; fetch advances or follows a fresh redirect
    // HOLD    | a redirect was seen during a stall and waits in pend_tgt
    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    generate
        if (ADDR_W < 28 || ADDR_W > 32) begin : g_bad_addr_w
            $error("pc_gen_unit: ADDR_W must be in 28..32");
        end
        if (RAS_DEPTH < 2 || RAS_DEPTH > 16 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_ras_depth
            $error("pc_gen_unit: RAS_DEPTH must be a power of 2 in 2..16");
        end
    endgenerate

    state_t            state;
    logic [ADDR_W-1:0] pc_r;
    logic [ADDR_W-1:0] pend_tgt;
    logic [ADDR_W-1:0] br_tgt;
    logic [ADDR_W-1:0] j_tgt;
    logic [ADDR_W-1:0] jmp_tgt;

    assign br_tgt = id_pc4 + {{(ADDR_W-18){imm16[15]}}, imm16, 2'b00};

    // J target keeps the upper region bits of the delay-slot PC when the PC is wider than 28 bits
    generate
        if (ADDR_W > 28) begin : g_j_region
            assign j_tgt = {id_pc4[ADDR_W-1:28], imm26, 2'b00};
        end else begin : g_j_flat
            assign j_tgt = {imm26, 2'b00};
        end
    endgenerate

    assign if_jump = (npc_sel == 2'd2) | (npc_sel == 2'd3) | ((npc_sel == 2'd1) & judge);

    // Select the redirect target for the current ID-stage jump kind
    always_comb begin
        jmp_tgt = br_tgt;
        case (npc_sel)
            2'd2:    jmp_tgt = j_tgt;
            2'd3:    jmp_tgt = rs_out;
            default: jmp_tgt = br_tgt;
        endcase
    end

    // PC register and pending-redirect FSM; the if/else chain is the edge priority order
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_r     <= RESET_PC[ADDR_W-1:0];
            pend_tgt <= '0;
            state    <= ST_RUN;
        end else if (exc_req) begin
            pc_r     <= EXC_VEC[ADDR_W-1:0];
            pend_tgt <= '0;
            state    <= ST_RUN;
        end else if (eret) begin
            pc_r     <= epc;
            pend_tgt <= '0;
            state    <= ST_RUN;
        end else if (stall) begin
            // a newer redirect simply overwrites an older pending one
            if (if_jump) begin
                pend_tgt <= jmp_tgt;
                state    <= ST_HOLD;
            end
        end else if (if_jump) begin
            pc_r  <= jmp_tgt;
            state <= ST_RUN;
        end else if (state == ST_HOLD) begin
            pc_r  <= pend_tgt;
            state <= ST_RUN;
        end else begin
            pc_r <= pc_r + ADDR_W'(4);
        end
    end

    assign pc         = pc_r;
    assign pc4        = pc_r + ADDR_W'(4);
    assign pend_valid = (state == ST_HOLD);

`ifdef PC_GEN_RAS_EN
    localparam int RAS_AW = $clog2(RAS_DEPTH);

    logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
    logic [RAS_AW-1:0] ras_ptr;
    logic [RAS_AW-1:0] ras_top_idx;
    logic [RAS_AW-1:0] ras_wr_idx;
    logic [RAS_AW:0]   ras_cnt;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_pop_eff;
    logic              ras_empty;
    logic              ras_full;

    assign ras_push    = is_call & if_jump & ~stall;
    assign ras_pop     = is_ret & if_jump & ~stall;
    assign ras_empty   = (ras_cnt == '0);
    assign ras_full    = (ras_cnt == (RAS_AW+1)'(RAS_DEPTH));
    assign ras_pop_eff = ras_pop & ~ras_empty;
    assign ras_top_idx = ras_ptr - RAS_AW'(1);
    // pop-then-push in one cycle replaces the top entry in place
    assign ras_wr_idx  = ras_pop_eff ? ras_top_idx : ras_ptr;
    // advisory only: flags a return whose predicted address disagrees with rs_out
    assign ras_miss    = ras_pop & (ras_empty | (ras_mem[ras_top_idx] != rs_out));

    // Stack storage; circular so a push on full overwrites the oldest entry
    always_ff @(posedge clk) begin
        if (ras_push && !exc_req) begin
            ras_mem[ras_wr_idx] <= id_pc4 + ADDR_W'(4);
        end
    end

    // Stack pointer and occupancy; exception entry empties the stack
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (exc_req) begin
            ras_ptr <= '0;
            ras_cnt <= '0;
        end else if (ras_push && !ras_pop_eff) begin
            ras_ptr <= ras_ptr + RAS_AW'(1);
            if (!ras_full) begin
                ras_cnt <= ras_cnt + (RAS_AW+1)'(1);
            end
        end else if (ras_pop_eff && !ras_push) begin
            ras_ptr <= ras_top_idx;
            ras_cnt <= ras_cnt - (RAS_AW+1)'(1);
        end
    end
`else
    // without the stack these hints have no effect
    assign ras_miss = 1'b0 & (is_call | is_ret);
`endif

endmodule

// File: tb/tb_pc_gen_unit.sv
// tb_pc_gen_unit: directed vector bench for pc_gen_unit (default parameters).
module tb_pc_gen_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [1:0]  npc_sel;
    logic        judge;
    logic [31:0] id_pc4;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] rs_out;
    logic        is_call;
    logic        is_ret;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        if_jump;
    logic        pend_valid;
    logic        ras_miss;

    int n_cmp = 0;
    int n_bad = 0;

    pc_gen_unit dut (
        .clk        (clk),
        .reset      (reset),
        .stall      (stall),
        .npc_sel    (npc_sel),
        .judge      (judge),
        .id_pc4     (id_pc4),
        .imm16      (imm16),
        .imm26      (imm26),
        .rs_out     (rs_out),
        .is_call    (is_call),
        .is_ret     (is_ret),
        .exc_req    (exc_req),
        .eret       (eret),
        .epc        (epc),
        .pc         (pc),
        .pc4        (pc4),
        .if_jump    (if_jump),
        .pend_valid (pend_valid),
        .ras_miss   (ras_miss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic [1:0]  sel;
        logic        judge;
        logic [31:0] id_pc4;
        logic [15:0] imm16;
        logic [25:0] imm26;
        logic [31:0] rs;
        logic        exc;
        logic        eret;
        logic [31:0] epc;
        logic        e_ifj;
        logic [31:0] e_pc;
        logic        e_pend;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic st, logic [1:0] sel, logic jd, logic [31:0] ip4,
                                logic [15:0] i16, logic [25:0] i26, logic [31:0] rs,
                                logic ex, logic er, logic [31:0] ep,
                                logic e_ifj, logic [31:0] e_pc, logic e_pend);
        vec_t v;
        v.stall = st;   v.sel = sel;   v.judge = jd;  v.id_pc4 = ip4;
        v.imm16 = i16;  v.imm26 = i26; v.rs = rs;     v.exc = ex;
        v.eret = er;    v.epc = ep;    v.e_ifj = e_ifj;
        v.e_pc = e_pc;  v.e_pend = e_pend;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        stall = 0; npc_sel = 0; judge = 0; id_pc4 = 0; imm16 = 0; imm26 = 0;
        rs_out = 0; is_call = 0; is_ret = 0; exc_req = 0; eret = 0; epc = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;

        // idle cycles
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 0, 32'h0,    0, 32'h0000_3004, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 0, 32'h0,    0, 32'h0000_3008, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 0, 32'h0,    0, 32'h0000_300C, 0));
        // taken / not-taken branch
        vecs.push_back(mk(0, 1, 1, 32'h0000_3010, 16'hFFFC, 26'h0,       32'h0,         0, 0, 32'h0,    1, 32'h0000_3000, 0));
        vecs.push_back(mk(0, 1, 0, 32'h0000_3010, 16'hFFFC, 26'h0,       32'h0,         0, 0, 32'h0,    0, 32'h0000_3004, 0));
        // J under stall, then release
        vecs.push_back(mk(1, 2, 0, 32'h0000_3008, 16'h0,    26'h0000C40, 32'h0,         0, 0, 32'h0,    1, 32'h0000_3004, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 0, 32'h0,    0, 32'h0000_3100, 0));
        // HOLD then exception (with stall), eret, exc+eret together
        vecs.push_back(mk(1, 2, 0, 32'h0000_3104, 16'h0,    26'h0000C40, 32'h0,         0, 0, 32'h0,    1, 32'h0000_3100, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 0, 32'h0,    0, 32'h0000_3100, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         1, 0, 32'h0,    0, 32'h0000_4180, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 1, 32'h0000_3020, 0, 32'h0000_3020, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         1, 1, 32'h0000_3020, 0, 32'h0000_4180, 0));
        // JR, then fresh redirect beats pending
        vecs.push_back(mk(0, 3, 0, 32'h0,         16'h0,    26'h0,       32'h1234_5678, 0, 0, 32'h0,    1, 32'h1234_5678, 0));
        vecs.push_back(mk(1, 3, 0, 32'h0,         16'h0,    26'h0,       32'h0000_5000, 0, 0, 32'h0,    1, 32'h1234_5678, 1));
        vecs.push_back(mk(1, 3, 0, 32'h0,         16'h0,    26'h0,       32'h0000_6000, 0, 0, 32'h0,    1, 32'h1234_5678, 1));
        vecs.push_back(mk(0, 2, 0, 32'h0000_3000, 16'h0,    26'h0000001, 32'h0,         0, 0, 32'h0,    1, 32'h0000_0004, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 0, 32'h0,    0, 32'h0000_0008, 0));
        // newer stalled redirect overwrites older pending
        vecs.push_back(mk(1, 3, 0, 32'h0,         16'h0,    26'h0,       32'h0000_5000, 0, 0, 32'h0,    1, 32'h0000_0008, 1));
        vecs.push_back(mk(1, 3, 0, 32'h0,         16'h0,    26'h0,       32'h0000_6000, 0, 0, 32'h0,    1, 32'h0000_0008, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 0, 32'h0,    0, 32'h0000_6000, 0));
        // wrap at top of address space
        vecs.push_back(mk(0, 3, 0, 32'h0,         16'h0,    26'h0,       32'hFFFF_FFFC, 0, 0, 32'h0,    1, 32'hFFFF_FFFC, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 0, 32'h0,    0, 32'h0000_0000, 0));
        // forward branch, J with region bits, stalled not-taken branch
        vecs.push_back(mk(0, 1, 1, 32'h0000_4000, 16'h0010, 26'h0,       32'h0,         0, 0, 32'h0,    1, 32'h0000_4040, 0));
        vecs.push_back(mk(0, 2, 0, 32'hA000_0000, 16'h0,    26'h3FFFFFF, 32'h0,         0, 0, 32'h0,    1, 32'hAFFF_FFFC, 0));
        vecs.push_back(mk(1, 1, 0, 32'h0000_1000, 16'h0040, 26'h0,       32'h0,         0, 0, 32'h0,    0, 32'hAFFF_FFFC, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         16'h0,    26'h0,       32'h0,         0, 0, 32'h0,    0, 32'hB000_0000, 0));

        // reset state
        tick();
        tick();
        reset = 1'b0;
        #1;
        check("reset_pc", pc, 32'h0000_3000);
        check("reset_pc4", pc4, 32'h0000_3004);
        check("reset_pend", {31'b0, pend_valid}, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            stall   = vecs[i].stall;
            npc_sel = vecs[i].sel;
            judge   = vecs[i].judge;
            id_pc4  = vecs[i].id_pc4;
            imm16   = vecs[i].imm16;
            imm26   = vecs[i].imm26;
            rs_out  = vecs[i].rs;
            exc_req = vecs[i].exc;
            eret    = vecs[i].eret;
            epc     = vecs[i].epc;
            #1;
            check($sformatf("v%0d_if_jump", i), {31'b0, if_jump}, {31'b0, vecs[i].e_ifj});
            check($sformatf("v%0d_ras_miss", i), {31'b0, ras_miss}, 32'h0);
            tick();
            check($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            check($sformatf("v%0d_pc4", i), pc4, vecs[i].e_pc + 32'd4);
            check($sformatf("v%0d_pend", i), {31'b0, pend_valid}, {31'b0, vecs[i].e_pend});
        end

        // asynchronous reset in the middle of HOLD
        idle_inputs();
        stall = 1; npc_sel = 2; id_pc4 = 32'h0000_3000; imm26 = 26'h0000C40;
        tick();
        check("hold_before_reset", {31'b0, pend_valid}, 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check("async_reset_pc", pc, 32'h0000_3000);
        check("async_reset_pend", {31'b0, pend_valid}, 32'h0);
        reset = 1'b0;
        idle_inputs();
        tick();
        check("after_reset_pc", pc, 32'h0000_3004);
        check("after_reset_pend", {31'b0, pend_valid}, 32'h0);

`ifdef PC_GEN_RAS_EN
        // five calls into a four-deep stack, then five returns
        for (int k = 1; k <= 5; k++) begin
            idle_inputs();
            npc_sel = 2; is_call = 1; id_pc4 = 32'h1000 * k; imm26 = 26'h0000400;
            tick();
        end
        for (int k = 0; k < 5; k++) begin
            idle_inputs();
            npc_sel = 3; is_ret = 1; rs_out = 32'h1000 * (5 - k) + 32'd4;
            #1;
            check($sformatf("ras_pop%0d_miss", k), {31'b0, ras_miss}, (k == 4) ? 32'h1 : 32'h0);
            tick();
            check($sformatf("ras_pop%0d_pc", k), pc, 32'h1000 * (5 - k) + 32'd4);
        end
        idle_inputs();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
